conv_4_mac_pipe_dsp: RTL and testbench

//  Pipelined signed multiply-accumulate engine for the conv layers. Generalises the

---
 rtl/conv_4_mac_pipe_dsp.sv | 151 +++++++++++++++
 tb/tb_conv_4_mac_pipe_dsp.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_4_mac_pipe_dsp.sv
// ============================================================================
//  Module   : conv_4_mac_pipe_dsp
//  Purpose  : Pipelined signed MAC with a saturating, group-framed accumulator
//             and valid/ready handshakes on both sides.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module conv_4_mac_pipe_dsp #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 8,
    parameter int ACC_WIDTH = 32,
    parameter int NUM_STAGE = 3,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [A_WIDTH-1:0]   din0,
    input  logic signed [B_WIDTH-1:0]   din1,
    input  logic                        in_first,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] dout,
    output logic                        out_ovf
);

    localparam logic signed [ACC_WIDTH-1:0] c_acc_max = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] c_acc_min = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic                        w_en;
    logic                        w_accept;
    logic                        w_fire;
    logic signed [ACC_WIDTH-1:0] w_a;
    logic signed [ACC_WIDTH-1:0] w_b;
    logic signed [ACC_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0] w_base;
    logic signed [ACC_WIDTH:0]   w_sum;
    logic                        w_ovf;

    logic [NUM_STAGE-1:0]        stg_v_q;
    logic [NUM_STAGE-1:0]        stg_f_q;
    logic [NUM_STAGE-1:0]        stg_l_q;
    logic signed [ACC_WIDTH-1:0] stg_p_q [NUM_STAGE];

    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic                        sticky_q;
    logic                        sticky_d;

    logic                        res_v_q;
    logic signed [ACC_WIDTH-1:0] res_q;
    logic                        res_ovf_q;

    logic                        out_valid_q;
    logic signed [ACC_WIDTH-1:0] dout_q;
    logic                        out_ovf_q;

    // A pending, unaccepted result freezes every stage of the engine.
    assign w_en     = !out_valid_q || out_ready;
    assign in_ready = w_en;
    assign w_accept = in_valid && w_en;
    assign w_fire   = w_en && stg_v_q[NUM_STAGE-1];

    // Operands are widened first so the product is exact at ACC_WIDTH bits.
    assign w_a    = ACC_WIDTH'(din0);
    assign w_b    = ACC_WIDTH'(din1);
    assign w_prod = w_a * w_b;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            stg_v_q <= '0;
            stg_f_q <= '0;
            stg_l_q <= '0;
            for (int i = 0; i < NUM_STAGE; i++) begin
                stg_p_q[i] <= '0;
            end
        end else if (w_en) begin
            stg_v_q[0] <= w_accept;
            stg_f_q[0] <= in_first;
            stg_l_q[0] <= in_last;
            stg_p_q[0] <= w_prod;
            for (int i = 1; i < NUM_STAGE; i++) begin
                stg_v_q[i] <= stg_v_q[i-1];
                stg_f_q[i] <= stg_f_q[i-1];
                stg_l_q[i] <= stg_l_q[i-1];
                stg_p_q[i] <= stg_p_q[i-1];
            end
        end
    end

    // One extra bit of headroom exposes overflow as a sign-bit disagreement.
    always_comb begin
        w_base   = stg_f_q[NUM_STAGE-1] ? '0 : acc_q;
        w_sum    = (ACC_WIDTH+1)'(w_base) + (ACC_WIDTH+1)'(stg_p_q[NUM_STAGE-1]);
        w_ovf    = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
        acc_d    = w_sum[ACC_WIDTH-1:0];
        if (SATURATE && w_ovf) begin
            acc_d = w_sum[ACC_WIDTH] ? c_acc_min : c_acc_max;
        end
        sticky_d = (stg_f_q[NUM_STAGE-1] ? 1'b0 : sticky_q) | w_ovf;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q    <= '0;
            sticky_q <= 1'b0;
        end else if (w_fire) begin
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            res_v_q   <= 1'b0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
        end else if (w_en) begin
            res_v_q <= w_fire && stg_l_q[NUM_STAGE-1];
            if (w_fire && stg_l_q[NUM_STAGE-1]) begin
                res_q     <= acc_d;
                res_ovf_q <= sticky_d;
            end
        end
    end

    // Output register: loading a new result while the old one is taken keeps full rate.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            out_ovf_q   <= 1'b0;
        end else if (w_en) begin
            out_valid_q <= res_v_q;
            if (res_v_q) begin
                dout_q    <= res_q;
                out_ovf_q <= res_ovf_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign out_ovf   = out_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_4_mac_pipe_dsp.sv
// ============================================================================
//  Module   : tb_conv_4_mac_pipe_dsp
//  Purpose  : Self-checking bench for conv_4_mac_pipe_dsp (32-bit saturating,
//             24-bit saturating and 24-bit wrapping instances on shared stimulus).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_conv_4_mac_pipe_dsp;

    localparam int NS = 3;

    logic               ap_clk    = 1'b0;
    logic               ap_rst_n  = 1'b0;
    logic               in_valid  = 1'b0;
    logic               in_first  = 1'b0;
    logic               in_last   = 1'b0;
    logic               out_ready = 1'b1;
    logic signed [15:0] din0      = '0;
    logic signed [7:0]  din1      = '0;

    logic               in_ready, out_valid, out_ovf;
    logic signed [31:0] dout;
    logic               in_ready_s, out_valid_s, out_ovf_s;
    logic signed [23:0] dout_s;
    logic               in_ready_w, out_valid_w, out_ovf_w;
    logic signed [23:0] dout_w;

    always #5 ap_clk = ~ap_clk;

    conv_4_mac_pipe_dsp #(.A_WIDTH(16), .B_WIDTH(8), .ACC_WIDTH(32), .NUM_STAGE(NS), .SATURATE(1'b1)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .out_ovf(out_ovf));

    conv_4_mac_pipe_dsp #(.A_WIDTH(16), .B_WIDTH(8), .ACC_WIDTH(24), .NUM_STAGE(NS), .SATURATE(1'b1)) dut_s (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid_s), .out_ready(out_ready), .dout(dout_s), .out_ovf(out_ovf_s));

    conv_4_mac_pipe_dsp #(.A_WIDTH(16), .B_WIDTH(8), .ACC_WIDTH(24), .NUM_STAGE(NS), .SATURATE(1'b0)) dut_w (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid_w), .out_ready(out_ready), .dout(dout_w), .out_ovf(out_ovf_w));

    typedef struct {
        longint e32; bit o32;
        longint es;  bit os;
        longint ew;  bit ow;
    } exp_t;

    exp_t   exp_q[$];
    longint cur[$];
    exp_t   e_mon;
    int     n_tests = 0;
    int     n_fail  = 0;
    int     n_last  = 0;
    int     n_out   = 0;

    // Dot product of a group's products at width w, clamped or wrapped.
    function automatic void ref_group(input longint ps[$], input int w, input bit sat,
                                      output longint r, output bit o);
        longint mx = (longint'(1) <<< (w-1)) - 1;
        longint mn = -mx - 1;
        longint acc = 0;
        o = 1'b0;
        foreach (ps[i]) begin
            acc = acc + ps[i];
            if (acc > mx || acc < mn) begin
                o = 1'b1;
                if (sat)           acc = (acc > mx) ? mx : mn;
                else if (acc > mx) acc = acc - (longint'(1) <<< w);
                else               acc = acc + (longint'(1) <<< w);
            end
        end
        r = acc;
    endfunction

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic send(input logic signed [15:0] a, input logic signed [7:0] b,
                        input bit f, input bit l);
        int   n   = 0;
        bit   rdy = 1'b0;
        exp_t e;
        din0 = a; din1 = b; in_first = f; in_last = l; in_valid = 1'b1;
        do begin
            @(negedge ap_clk);
            rdy = in_ready;
            @(posedge ap_clk);
            #1;
            n++;
        end while (!rdy && n < 300);
        in_valid = 1'b0;
        if (!rdy) begin
            check("accept_timeout", 64'(rdy), 64'd1);
        end else begin
            if (f) cur.delete();
            cur.push_back(longint'(a) * longint'(b));
            if (l) begin
                ref_group(cur, 32, 1'b1, e.e32, e.o32);
                ref_group(cur, 24, 1'b1, e.es,  e.os);
                ref_group(cur, 24, 1'b0, e.ew,  e.ow);
                exp_q.push_back(e);
                n_last++;
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge ap_clk);
            #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge ap_clk);
            #1;
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: every accepted result is matched in order against the model.
    always @(negedge ap_clk) begin
        if (ap_rst_n && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("extra_result", 64'(out_valid), 64'd0);
            end else begin
                e_mon = exp_q.pop_front();
                check("dout32",  dout,        e_mon.e32);
                check("ovf32",   out_ovf,     64'(e_mon.o32));
                check("valid_s", out_valid_s, 64'd1);
                check("dout_s",  dout_s,      e_mon.es);
                check("ovf_s",   out_ovf_s,   64'(e_mon.os));
                check("valid_w", out_valid_w, 64'd1);
                check("dout_w",  dout_w,      e_mon.ew);
                check("ovf_w",   out_ovf_w,   64'(e_mon.ow));
            end
        end
    end

    initial begin
        logic signed [15:0] ra;
        logic signed [7:0]  rb;
        int                 len;
        int                 n;

        // Reset state
        repeat (2) @(posedge ap_clk);
        #1;
        check("rst_valid", out_valid, 64'd0);
        check("rst_dout",  dout,      64'd0);
        check("rst_ovf",   out_ovf,   64'd0);
        check("rst_ready", in_ready,  64'd1);
        ap_rst_n = 1'b1;
        idle(2);

        // Single beat with exact latency
        send(16'sd100, -8'sd3, 1'b1, 1'b1);
        for (int k = 0; k <= NS + 1; k++) begin
            @(negedge ap_clk);
            check("t1_latency", out_valid, 64'(k == NS + 1));
        end
        check("t1_dout", dout,    -64'sd300);
        check("t1_ovf",  out_ovf, 64'd0);
        #1;
        drain();

        // Group of four including the MIN*MIN product
        send(16'sd1000,   8'sd2,    1'b1, 1'b0);
        send(-16'sd50,    8'sd7,    1'b0, 1'b0);
        send(16'sd32767,  8'sd127,  1'b0, 1'b0);
        send(-16'sd32768, -8'sd128, 1'b0, 1'b1);
        drain();

        // Overflow of the 24-bit instances
        for (int i = 0; i < 4; i++) send(16'sd32767, 8'sd127, i == 0, i == 3);
        drain();

        // Backpressure with a result pending and input still offered
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    ra = 16'($urandom);
                    rb = 8'($urandom);
                    send(ra, rb, 1'b1, 1'b1);
                end
            end
            begin
                n = 0;
                do begin
                    @(negedge ap_clk);
                    n++;
                end while (!out_valid && n < 50);
                check("t4_pending", out_valid, 64'd1);
                if (exp_q.size() != 0) begin
                    for (int i = 0; i < 5; i++) begin
                        check("t4_in_ready",   in_ready,   64'd0);
                        check("t4_in_ready_s", in_ready_s, 64'd0);
                        check("t4_in_ready_w", in_ready_w, 64'd0);
                        check("t4_dout_hold",  dout,       exp_q[0].e32);
                        @(negedge ap_clk);
                    end
                end
                @(posedge ap_clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Random groups with input bubbles
        for (int g = 0; g < 64; g++) begin
            len = $urandom_range(1, 9);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 1) == 1) idle(1);
                ra = 16'($urandom);
                rb = 8'($urandom);
                send(ra, rb, b == 0, b == len - 1);
            end
        end
        drain();

        // Reset mid-group, then a group without a first flag
        send(16'sd1234, 8'sd55, 1'b1, 1'b0);
        send(16'sd4321, 8'sd66, 1'b0, 1'b0);
        ap_rst_n = 1'b0;
        #1;
        check("t6_valid",  out_valid, 64'd0);
        check("t6_dout",   dout,      64'd0);
        check("t6_ovf",    out_ovf,   64'd0);
        check("t6_dout_s", dout_s,    64'd0);
        cur.delete();
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        idle(1);
        send(16'sd300,  8'sd5,  1'b0, 1'b0);
        send(-16'sd20,  8'sd9,  1'b0, 1'b0);
        send(16'sd7,    -8'sd4, 1'b0, 1'b1);
        drain();

        idle(4);
        check("result_count", 64'(n_out), 64'(n_last));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
